btn_sw_capture: RTL and testbench
=================================

BTN_SW_CAPTURE -- requirements
Module: btn_sw_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the cycles of input stability required before a change is accepted (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Port clk_clk, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-003 Port reset_reset, input, 1, SHALL be the reset, synchronous and active-high.
REQ-004 Port btn_pin_export, input, 2, SHALL carry the raw asynchronous push-buttons, active-low (0 = pressed).
REQ-005 Port sw_pin_export, input, 8, SHALL carry the raw asynchronous slide switches.
REQ-006 Port avs_address, input, 2, SHALL be the word address of the slave register.
REQ-007 Port avs_read, input, 1, SHALL be the read strobe.
REQ-008 Port avs_write, input, 1, SHALL be the write strobe.
REQ-009 Port avs_writedata, input, 32, SHALL be the write data.
REQ-010 Port avs_readdata, output, 32, SHALL be the read data.
REQ-011 Port irq, output, 1, SHALL be the level interrupt to the processor.

Function
REQ-012 Each of the 10 input bits ({btn[1:0], sw[7:0]}) SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Each bit SHALL have a 16-bit stability counter: cleared whenever the synchronized value differs from the previous synchronized sample; otherwise incremented, saturating.
REQ-014 The debounced value of a bit SHALL update to the synchronized value in the cycle its counter reaches DEBOUNCE_CYCLES-1; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change it.
REQ-015 Press of button n SHALL mean a 1->0 transition of the debounced btn bit; it SHALL set edge bit 8+n for exactly that event, and release SHALL set nothing.
REQ-016 Any debounced transition of switch k, either direction, SHALL set edge bit k.
REQ-017 Register map: address 0 DATA (RO): [9:8] debounced btn, [7:0] debounced sw, [31:10] zero.
REQ-018 Address 1 MASK (RW): [9:0] interrupt enable, [31:10] read zero, writes ignored there.
REQ-019 Address 2 EDGE (R/W1C): [9:0] sticky edge flags; writing 1 clears a bit, writing 0 leaves it.
REQ-020 Address 3 ID (RO): constant 32'h0B70_0001.
REQ-021 Writes to RO addresses SHALL have no effect.
REQ-022 Reads SHALL have fixed latency 1: avs_readdata is valid the cycle after avs_read is high, and holds until the next read.
REQ-023 A read SHALL have no side effect; EDGE is not cleared on read.
REQ-024 Write-1-to-clear and a new edge on the same bit in the same cycle: the set SHALL win and the bit stays 1.
REQ-025 irq SHALL be registered: irq = |(EDGE & MASK) from the previous cycle, one cycle latency.
REQ-026 avs_read and avs_write high together SHALL perform both, the read returning pre-write contents.

Reset
REQ-027 While reset_reset is high at a clock edge: synchronizers and debounced btn SHALL load 2'b11 (released), debounced sw and synchronizers 8'h00, counters 0, MASK 0, EDGE 0, avs_readdata 0, irq 0.
REQ-028 Reset asserted mid-debounce SHALL abandon the pending change; after release, a pin already at its new level SHALL need a full DEBOUNCE_CYCLES of stability to be accepted, and changes from the reset values SHALL set EDGE bits.
REQ-029 No output SHALL change in the cycle reset is released except by normal registered update.

Verification (DEBOUNCE_CYCLES=8 in bench)
REQ-030 Hold btn[0]=0 for 20 cycles after reset -> DATA[8]=0 about 10 cycles after the pin change (2 sync + 8); EDGE=10'h100; with MASK=10'h100, irq=1 one cycle later.
REQ-031 Pulse sw[3]=1 for 5 cycles, then 0 -> DATA and EDGE remain 0, irq stays 0.
REQ-032 With EDGE=10'h108, write addr 2 data 32'h008 -> EDGE reads 10'h100; write 32'h100 in the same cycle as a new btn[0] press edge -> EDGE[8] stays 1.
REQ-033 Read addr 3 -> avs_readdata=32'h0B700001 exactly one cycle after avs_read; write 32'hFFFFFFFF to addr 1 then read -> 32'h000003FF.
REQ-034 Assert reset_reset 4 cycles into a btn[1] debounce -> after release, all outputs reset; DATA[9] goes 0 only after a full 8+2 stable cycles; EDGE[9] then set.

Source files
------------

// File: rtl/btn_sw_capture.sv
// -----------------------------------------------------------------------------
// btn_sw_capture
//
// Captures two active-low push-buttons and eight slide switches for a
// processor on an Avalon-MM style slave. Every raw pin is synchronized,
// debounced with a per-bit stability counter, and watched for accepted
// transitions. Those transitions latch into sticky edge flags, which can raise
// a level interrupt through a mask register.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles of stability needed before a pin change is
//                     accepted (2..65535, default 1 ms at 50 MHz)
//
// Ports
//   clk_clk        : single rising-edge clock
//   reset_reset    : synchronous active-high reset
//   btn_pin_export : raw push-buttons, active-low (0 = pressed)
//   sw_pin_export  : raw slide switches
//   avs_address    : register word address
//   avs_read       : read strobe, data returned one cycle later
//   avs_write      : write strobe
//   avs_writedata  : write data
//   avs_readdata   : registered read data, held until the next read
//   irq            : registered level interrupt, |(EDGE & MASK)
//
// Register map
//   0 DATA (RO)   [9:8] debounced buttons, [7:0] debounced switches
//   1 MASK (RW)   [9:0] interrupt enables
//   2 EDGE (W1C)  [9:0] sticky edge flags (bit 8+n = press of button n,
//                 bit k = any change of switch k)
//   3 ID   (RO)   32'h0B70_0001
// -----------------------------------------------------------------------------
module btn_sw_capture #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  btn_pin_export,
  input  logic [7:0]  sw_pin_export,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int NUM_BITS = 10;

  // Buttons idle high (released), switches come out of reset as zero.
  localparam logic [NUM_BITS-1:0] PIN_RESET = 10'b11_0000_0000;

  localparam logic [15:0] CNT_TERMINAL = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  localparam logic [31:0] ID_VALUE = 32'h0B70_0001;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_ID   = 2'd3;

  logic [NUM_BITS-1:0] pins;
  logic [NUM_BITS-1:0] sync_meta;
  logic [NUM_BITS-1:0] sync_stable;
  logic [NUM_BITS-1:0] sync_prev;
  logic [15:0]         stable_cnt [NUM_BITS];
  logic [NUM_BITS-1:0] accept;
  logic [NUM_BITS-1:0] debounced;
  logic [NUM_BITS-1:0] debounced_next;
  logic [NUM_BITS-1:0] new_edges;
  logic [NUM_BITS-1:0] mask;
  logic [NUM_BITS-1:0] edge_flags;
  logic [NUM_BITS-1:0] edge_clear;
  logic [NUM_BITS-1:0] edge_next;
  logic                write_mask;
  logic                write_edge;
  logic [31:0]         read_mux;
  logic                unused_writedata;

  // Buttons occupy the top two bits so the internal vector lines up with the
  // DATA/MASK/EDGE register layout.
  assign pins = {btn_pin_export, sw_pin_export};

  // Only the low ten write-data bits map onto register storage.
  assign unused_writedata = ^avs_writedata[31:NUM_BITS];

  // Two-flop synchronizer, plus one extra stage holding the previous
  // synchronized sample so the stability counter can spot a change.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_meta   <= PIN_RESET;
      sync_stable <= PIN_RESET;
      sync_prev   <= PIN_RESET;
    end else begin
      sync_meta   <= pins;
      sync_stable <= sync_meta;
      sync_prev   <= sync_stable;
    end
  end

  // Per-bit stability counters. Any change restarts the count; a long-stable
  // pin parks at the saturation value instead of wrapping back through the
  // terminal count.
  always_ff @(posedge clk_clk) begin
    for (int i = 0; i < NUM_BITS; i++) begin
      if (reset_reset) begin
        stable_cnt[i] <= '0;
      end else if (sync_stable[i] != sync_prev[i]) begin
        stable_cnt[i] <= '0;
      end else if (stable_cnt[i] != CNT_MAX) begin
        stable_cnt[i] <= stable_cnt[i] + 16'd1;
      end
    end
  end

  // A bit is accepted on the single cycle its counter sits at the terminal
  // count with the input still unchanged. Buttons raise an edge only on the
  // press (1 -> 0). Switches raise one on either direction.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      accept[i] = (sync_stable[i] == sync_prev[i]) && (stable_cnt[i] == CNT_TERMINAL);
    end
    debounced_next = (debounced & ~accept) | (sync_stable & accept);
    new_edges      = '0;
    new_edges[7:0] = debounced_next[7:0] ^ debounced[7:0];
    new_edges[9:8] = debounced[9:8] & ~debounced_next[9:8];
  end

  // Debounced pin state.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      debounced <= PIN_RESET;
    end else begin
      debounced <= debounced_next;
    end
  end

  assign write_mask = avs_write && (avs_address == ADDR_MASK);
  assign write_edge = avs_write && (avs_address == ADDR_EDGE);

  // Write-one-to-clear is applied first and new edges are ORed in afterwards,
  // so an edge arriving in the same cycle as its clear survives.
  assign edge_clear = write_edge ? avs_writedata[NUM_BITS-1:0] : '0;
  assign edge_next  = (edge_flags & ~edge_clear) | new_edges;

  // Mask and sticky edge registers. The interrupt is registered from the
  // current register contents, giving one cycle of latency.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mask       <= '0;
      edge_flags <= '0;
      irq        <= 1'b0;
    end else begin
      if (write_mask) begin
        mask <= avs_writedata[NUM_BITS-1:0];
      end
      edge_flags <= edge_next;
      irq        <= |(edge_flags & mask);
    end
  end

  // Read multiplexer. It looks at register contents before any write in the
  // same cycle takes effect, so a simultaneous read and write returns the old
  // value.
  always_comb begin
    read_mux = '0;
    case (avs_address)
      ADDR_DATA: read_mux[NUM_BITS-1:0] = debounced;
      ADDR_MASK: read_mux[NUM_BITS-1:0] = mask;
      ADDR_EDGE: read_mux[NUM_BITS-1:0] = edge_flags;
      ADDR_ID:   read_mux = ID_VALUE;
      default:   read_mux = '0;
    endcase
  end

  // Read data is captured only on a read strobe and otherwise held. Reads
  // have no side effects on any register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_btn_sw_capture.sv
// -----------------------------------------------------------------------------
// tb_btn_sw_capture
//
// Self-checking bench for btn_sw_capture with DEBOUNCE_CYCLES = 8. The
// reference model describes each bit by how many consecutive cycles its
// synchronized level has held. A level is accepted once it has held for
// DEBOUNCE_CYCLES + 1 cycles: the cycle it changed, plus a full count of
// DEBOUNCE_CYCLES. Register behaviour is modelled directly from the register
// map. Directed scenarios come first, followed by a randomized stretch.
// -----------------------------------------------------------------------------
module tb_btn_sw_capture;

  localparam int D = 8;

  logic        clk;
  logic        reset_reset;
  logic [1:0]  btn_pin_export;
  logic [7:0]  sw_pin_export;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  int vectorCount;
  int missCount;

  // Reference model state
  logic [9:0]  mSamp1;
  logic [9:0]  mSamp2;
  logic [9:0]  mLast;
  int          mRun [10];
  logic [9:0]  mDeb;
  logic [9:0]  mMask;
  logic [9:0]  mEdge;
  logic        mIrq;
  logic [31:0] mRdata;

  // Current pin levels driven by the directed scenarios
  logic [1:0] curBtn;
  logic [7:0] curSw;
  logic       curRst;

  btn_sw_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_clk       (clk),
    .reset_reset   (reset_reset),
    .btn_pin_export(btn_pin_export),
    .sw_pin_export (sw_pin_export),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Register contents the model says a read of this address would return
  function automatic logic [31:0] regRead(input logic [1:0] addr);
    case (addr)
      2'd0:    return {22'd0, mDeb};
      2'd1:    return {22'd0, mMask};
      2'd2:    return {22'd0, mEdge};
      default: return 32'h0B70_0001;
    endcase
  endfunction

  // Advances the model across one rising edge using the inputs present at it
  task automatic modelStep();
    logic [9:0] pins;
    logic [9:0] syncLevel;
    logic [9:0] nextDeb;
    logic [9:0] setBits;
    logic [9:0] clrBits;
    if (reset_reset) begin
      mSamp1 = 10'h300;
      mSamp2 = 10'h300;
      mLast  = 10'h300;
      for (int b = 0; b < 10; b++) mRun[b] = 1;
      mDeb   = 10'h300;
      mMask  = '0;
      mEdge  = '0;
      mIrq   = 1'b0;
      mRdata = '0;
      return;
    end
    pins = {btn_pin_export, sw_pin_export};
    if (avs_read) mRdata = regRead(avs_address);
    mIrq = |(mEdge & mMask);
    syncLevel = mSamp2;
    nextDeb   = mDeb;
    for (int b = 0; b < 10; b++) begin
      if (syncLevel[b] == mLast[b]) begin
        if (mRun[b] < 70000) mRun[b] = mRun[b] + 1;
      end else begin
        mRun[b] = 1;
      end
      if (mRun[b] == D + 1) nextDeb[b] = syncLevel[b];
    end
    setBits = '0;
    for (int b = 0; b < 8; b++) setBits[b] = (nextDeb[b] != mDeb[b]);
    for (int b = 8; b < 10; b++) setBits[b] = mDeb[b] && !nextDeb[b];
    clrBits = (avs_write && avs_address == 2'd2) ? avs_writedata[9:0] : 10'd0;
    mEdge = (mEdge & ~clrBits) | setBits;
    if (avs_write && avs_address == 2'd1) mMask = avs_writedata[9:0];
    mDeb   = nextDeb;
    mLast  = syncLevel;
    mSamp2 = mSamp1;
    mSamp1 = pins;
  endtask

  // Drives one cycle of inputs, steps the model and compares both outputs
  task automatic applyStimulus(input logic rst, input logic [1:0] btn,
                               input logic [7:0] sw, input logic rd,
                               input logic wr, input logic [1:0] addr,
                               input logic [31:0] wdata);
    reset_reset    = rst;
    btn_pin_export = btn;
    sw_pin_export  = sw;
    avs_read       = rd;
    avs_write      = wr;
    avs_address    = addr;
    avs_writedata  = wdata;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("readdata", avs_readdata, mRdata);
    checkOutput("irq", {31'd0, irq}, {31'd0, mIrq});
  endtask

  // Directed-scenario helpers using the current pin levels
  task automatic busCycle(input logic rd, input logic wr, input logic [1:0] addr,
                          input logic [31:0] wdata);
    applyStimulus(curRst, curBtn, curSw, rd, wr, addr, wdata);
  endtask

  task automatic idleRead(input int n);
    for (int i = 0; i < n; i++) busCycle(1'b1, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    int holdLeft;
    logic [1:0] rBtn;
    logic [7:0] rSw;
    logic rRst;
    vectorCount = 0;
    missCount   = 0;
    curBtn = 2'b11;
    curSw  = 8'h00;
    curRst = 1'b1;
    reset_reset    = 1'b1;
    btn_pin_export = 2'b11;
    sw_pin_export  = 8'h00;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_address    = 2'd0;
    avs_writedata  = 32'd0;

    // Reset state
    for (int i = 0; i < 3; i++) busCycle(1'b1, 1'b0, 2'd0, 32'd0);
    checkOutput("reset_rdata", avs_readdata, 32'd0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    curRst = 1'b0;

    // Button 0 press, edge flag and masked interrupt
    $display("[TB] button press debounce");
    curBtn = 2'b10;
    idleRead(20);
    checkOutput("press_data", avs_readdata, 32'h0000_0200);
    busCycle(1'b1, 1'b0, 2'd2, 32'd0);
    checkOutput("press_edge", avs_readdata, 32'h0000_0100);
    busCycle(1'b0, 1'b1, 2'd1, 32'h0000_0100);
    checkOutput("irq_latency", {31'd0, irq}, 32'd0);
    busCycle(1'b0, 1'b0, 2'd0, 32'd0);
    checkOutput("press_irq", {31'd0, irq}, 32'd1);

    // Return to idle with flags and mask cleared
    curBtn = 2'b11;
    idleRead(15);
    busCycle(1'b0, 1'b1, 2'd2, 32'h0000_03FF);
    busCycle(1'b0, 1'b1, 2'd1, 32'h0000_0000);
    idleRead(2);
    checkOutput("clear_irq", {31'd0, irq}, 32'd0);

    // Short switch glitch is rejected
    $display("[TB] switch glitch rejection");
    curSw = 8'h08;
    idleRead(5);
    curSw = 8'h00;
    idleRead(15);
    checkOutput("glitch_data", avs_readdata, 32'h0000_0300);
    busCycle(1'b1, 1'b0, 2'd2, 32'd0);
    checkOutput("glitch_edge", avs_readdata, 32'd0);
    checkOutput("glitch_irq", {31'd0, irq}, 32'd0);

    // Write-one-to-clear and set-wins collision
    $display("[TB] edge clear behaviour");
    curSw = 8'h08;
    idleRead(15);
    curBtn = 2'b10;
    idleRead(15);
    busCycle(1'b1, 1'b0, 2'd2, 32'd0);
    checkOutput("edge_both", avs_readdata, 32'h0000_0108);
    busCycle(1'b0, 1'b1, 2'd2, 32'h0000_0008);
    busCycle(1'b1, 1'b0, 2'd2, 32'd0);
    checkOutput("w1c_partial", avs_readdata, 32'h0000_0100);
    busCycle(1'b1, 1'b0, 2'd2, 32'd0);
    checkOutput("read_no_clear", avs_readdata, 32'h0000_0100);
    curBtn = 2'b11;
    idleRead(15);
    busCycle(1'b1, 1'b0, 2'd2, 32'd0);
    checkOutput("release_no_edge", avs_readdata, 32'h0000_0100);
    curBtn = 2'b10;
    idleRead(10);
    busCycle(1'b0, 1'b1, 2'd2, 32'h0000_0100);
    busCycle(1'b1, 1'b0, 2'd2, 32'd0);
    checkOutput("set_wins", avs_readdata, 32'h0000_0100);
    busCycle(1'b0, 1'b1, 2'd2, 32'h0000_0100);
    busCycle(1'b1, 1'b0, 2'd2, 32'd0);
    checkOutput("w1c_full", avs_readdata, 32'd0);

    // ID read latency, mask width, RO writes, read-during-write
    $display("[TB] register access");
    busCycle(1'b1, 1'b0, 2'd3, 32'd0);
    checkOutput("id_read", avs_readdata, 32'h0B70_0001);
    busCycle(1'b0, 1'b0, 2'd0, 32'd0);
    checkOutput("id_hold", avs_readdata, 32'h0B70_0001);
    busCycle(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF);
    busCycle(1'b1, 1'b0, 2'd1, 32'd0);
    checkOutput("mask_width", avs_readdata, 32'h0000_03FF);
    busCycle(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF);
    busCycle(1'b0, 1'b1, 2'd3, 32'h0000_0000);
    busCycle(1'b1, 1'b0, 2'd0, 32'd0);
    checkOutput("data_ro", avs_readdata, 32'h0000_0208);
    busCycle(1'b1, 1'b0, 2'd3, 32'd0);
    checkOutput("id_ro", avs_readdata, 32'h0B70_0001);
    busCycle(1'b1, 1'b1, 2'd1, 32'h0000_0000);
    checkOutput("rw_pre", avs_readdata, 32'h0000_03FF);
    busCycle(1'b1, 1'b0, 2'd1, 32'd0);
    checkOutput("rw_post", avs_readdata, 32'd0);

    // Reset in the middle of a button 1 debounce
    $display("[TB] reset mid-debounce");
    curBtn = 2'b11;
    curSw  = 8'h00;
    idleRead(15);
    busCycle(1'b0, 1'b1, 2'd2, 32'h0000_03FF);
    curBtn = 2'b01;
    idleRead(4);
    curRst = 1'b1;
    idleRead(2);
    checkOutput("midrst_rdata", avs_readdata, 32'd0);
    checkOutput("midrst_irq", {31'd0, irq}, 32'd0);
    curRst = 1'b0;
    idleRead(9);
    checkOutput("midrst_early", avs_readdata, 32'h0000_0300);
    idleRead(3);
    checkOutput("midrst_data", avs_readdata, 32'h0000_0100);
    busCycle(1'b1, 1'b0, 2'd2, 32'd0);
    checkOutput("midrst_edge", avs_readdata, 32'h0000_0200);

    // Randomized pins, bus traffic and occasional resets
    $display("[TB] randomized traffic");
    holdLeft = 0;
    rBtn = curBtn;
    rSw  = curSw;
    for (int i = 0; i < 3000; i++) begin
      if (holdLeft == 0) begin
        if ($urandom_range(0, 1) == 0) rBtn = rBtn ^ 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) rSw  = rSw ^ (8'd1 << $urandom_range(0, 7));
        holdLeft = int'($urandom_range(1, 14));
      end
      holdLeft--;
      rRst = ($urandom_range(0, 299) == 0);
      applyStimulus(rRst, rBtn, rSw, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                    $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
